// File: rtl/state_reg_arbiter.sv
// -----------------------------------------------------------------------------
// state_reg_arbiter
//
// Round-robin arbiter and sequencer for a shared 2-bit state register (two
// D flip-flops capturing X/Y and driving a 4-bit decoded Z). NREQ requesters
// compete to load a 2-bit code. The winner's code is driven onto x_out/y_out
// and held for HOLD_CYCLES cycles. At the end of the hold, the register's
// decoded Z (z_in) is compared with the expected decode of the held code. A
// match produces a one-cycle done pulse to the owner. A mismatch sets the
// sticky err flag.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous, active-high reset
//   req    : request level per requester
//   code   : per-requester code, code[2i+1]=X, code[2i]=Y
//   z_in   : decoded Z read back from the state register
//   x_out  : drives the register X input (registered)
//   y_out  : drives the register Y input (registered)
//   gnt    : one-hot grant pulse, 1 cycle (registered)
//   done   : one-hot load-confirmed pulse, 1 cycle (registered)
//   busy   : high while a code is being held (registered)
//   err    : sticky Z-mismatch flag, cleared only by reset (registered)
// -----------------------------------------------------------------------------
module state_reg_arbiter #(
    parameter int NREQ        = 4,   // 2..8
    parameter int HOLD_CYCLES = 2    // 2..16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] code,
    input  logic [3:0]        z_in,
    output logic              x_out,
    output logic              y_out,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              err
);

    localparam int            PW     = $clog2(NREQ);
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);
    localparam logic [3:0]    CNT_LD = 4'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              x_q,     x_d;
    logic              y_q,     y_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic              busy_q,  busy_d;
    logic              err_q,   err_d;

    // Per-requester view of the packed code bus.
    logic [1:0] code_arr [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_code
        assign code_arr[g] = code[2*g+1 -: 2];
    end

    // Expected register decode for s1=X, s0=Y.
    function automatic logic [3:0] decode_z(input logic s1, input logic s0);
        return {s1 & s0, s1 & ~s0, s1 ^ s0, s0};
    endfunction

    // Round-robin search: first set req at or after ptr, wrapping modulo NREQ.
    logic          found;
    logic [PW-1:0] win;
    logic [PW:0]   sum;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    {x_d, y_d} = code_arr[win];
                    gnt_d      = NREQ'(1) << win;
                    owner_d    = win;
                    ptr_d      = (win == LAST) ? '0 : win + 1'b1;
                    cnt_d      = CNT_LD;
                    busy_d     = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // z_in has been valid since one edge after the code was
                    // driven, so the register output is settled here.
                    if (z_in == decode_z(x_q, y_q)) begin
                        done_d = NREQ'(1) << owner_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_state_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_state_reg_arbiter
//
// Drives two arbiter instances: (NREQ=4, HOLD_CYCLES=2) with directed and
// random traffic, and (NREQ=2, HOLD_CYCLES=5) with one requester held high.
// Each instance sees a behavioural state register that captures x_out/y_out and
// feeds the decoded Z back on z_in. Expected outputs come from a
// transaction-level reference model stepped once per clock.
// -----------------------------------------------------------------------------
module tb_state_reg_arbiter;

    localparam int N1 = 4, H1 = 2;
    localparam int N2 = 2, H2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N1-1:0]  req;
    logic [2*N1-1:0] code;
    logic [3:0]     z_in;
    logic           x_out, y_out, busy, err;
    logic [N1-1:0]  gnt, done;

    logic [N2-1:0]  req2;
    logic [2*N2-1:0] code2;
    logic [3:0]     z_in2;
    logic           x_out2, y_out2, busy2, err2;
    logic [N2-1:0]  gnt2, done2;

    bit   force_bad;
    logic [1:0] sreg1, sreg2;

    state_reg_arbiter #(.NREQ(N1), .HOLD_CYCLES(H1)) dut (
        .clk(clk), .reset(reset), .req(req), .code(code), .z_in(z_in),
        .x_out(x_out), .y_out(y_out), .gnt(gnt), .done(done),
        .busy(busy), .err(err)
    );

    state_reg_arbiter #(.NREQ(N2), .HOLD_CYCLES(H2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .code(code2), .z_in(z_in2),
        .x_out(x_out2), .y_out(y_out2), .gnt(gnt2), .done(done2),
        .busy(busy2), .err(err2)
    );

    function automatic logic [3:0] dec(input logic s1, input logic s0);
        return {s1 & s0, s1 & ~s0, s1 ^ s0, s0};
    endfunction

    // Behavioural shared state register for each instance.
    always @(posedge clk) begin
        sreg1 <= reset ? 2'b00 : {x_out, y_out};
        sreg2 <= reset ? 2'b00 : {x_out2, y_out2};
    end
    assign z_in  = force_bad ? 4'b0000 : dec(sreg1[1], sreg1[0]);
    assign z_in2 = dec(sreg2[1], sreg2[0]);

    // Transaction-level reference model state.
    typedef struct {
        int         ptr;
        int         left;    // busy cycles still to run, 0 when idle
        int         owner;
        bit         x, y, busy, err;
        logic [7:0] gnt, done;
    } model_t;

    model_t m1, m2;
    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int last_g2    = -1;

    task automatic model_step(inout model_t m, input int n, input int h,
                              input bit rst, input logic [7:0] rq,
                              input logic [15:0] cd, input logic [3:0] z);
        bit found;
        m.gnt  = 8'h00;
        m.done = 8'h00;
        if (rst) begin
            m.ptr = 0; m.left = 0; m.owner = 0;
            m.x = 0; m.y = 0; m.busy = 0; m.err = 0;
        end else if (m.left == 0) begin
            found = 0;
            for (int k = 0; k < n; k++) begin
                int w;
                w = (m.ptr + k) % n;
                if (!found && rq[w]) begin
                    found   = 1;
                    m.x     = cd[2*w+1];
                    m.y     = cd[2*w];
                    m.gnt   = 8'(1) << w;
                    m.owner = w;
                    m.ptr   = (w + 1) % n;
                    m.left  = h;
                    m.busy  = 1;
                end
            end
        end else begin
            m.left = m.left - 1;
            if (m.left == 0) begin
                m.busy = 0;
                if (z == dec(m.x, m.y)) m.done = 8'(1) << m.owner;
                else                    m.err  = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: step the model on pre-edge inputs, then compare #1 after the edge.
    task automatic tick();
        model_step(m1, N1, H1, reset, 8'(req),  16'(code),  z_in);
        model_step(m2, N2, H2, reset, 8'(req2), 16'(code2), z_in2);
        @(posedge clk);
        #1;
        cyc++;
        vectors++;
        check("gnt",   8'(gnt),   m1.gnt);
        check("done",  8'(done),  m1.done);
        check("busy",  8'(busy),  8'(m1.busy));
        check("err",   8'(err),   8'(m1.err));
        check("x_out", 8'(x_out), 8'(m1.x));
        check("y_out", 8'(y_out), 8'(m1.y));
        check("gnt2",  8'(gnt2),  m2.gnt);
        check("done2", 8'(done2), m2.done);
        check("busy2", 8'(busy2), 8'(m2.busy));
        check("err2",  8'(err2),  8'(m2.err));
        if (reset) begin
            last_g2 = -1;
        end else if (gnt2 != '0) begin
            if (last_g2 >= 0) check("t6_period", 8'(cyc - last_g2), 8'd6);
            last_g2 = cyc;
        end
    endtask

    task automatic wait_gnt(input string tag, input logic [7:0] want);
        int i;
        i = 0;
        while (8'(gnt) !== want && i < 40) begin
            tick();
            i++;
        end
        check(tag, 8'(gnt), want);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < 40) begin
            tick();
            i++;
        end
        check(tag, 8'(busy), 8'h00);
    endtask

    initial begin
        reset = 1'b1; req = '0; code = '0; force_bad = 0;
        req2 = '0; code2 = 4'b0011;
        repeat (2) tick();
        check("reset_outputs", {x_out, y_out, busy, err, gnt}, 8'h00);
        reset = 1'b0;
        req2  = 2'b01;

        // 1: single request, code 10.
        req = 4'b0001; code = 8'b0000_0010;
        tick();
        check("t1_gnt", 8'(gnt), 8'h01);
        check("t1_xy",  8'({x_out, y_out}), 8'h02);
        req = '0;
        tick();
        check("t1_busy", 8'(busy), 8'h01);
        check("t1_z",    8'(z_in), 8'h06);
        tick();
        check("t1_done", 8'(done), 8'h01);
        check("t1_fall", 8'(busy), 8'h00);
        tick();

        // 2: all requesting, codes 00/01/10/11.
        req = 4'b1111; code = {2'b11, 2'b10, 2'b01, 2'b00};
        repeat (16) tick();

        // 3: pointer wrap after requester 3.
        wait_gnt("t3_reach3", 8'h08);
        req = 4'b1001;
        tick();
        wait_gnt("t3_wrap", 8'h01);

        // Random traffic.
        repeat (200) begin
            req  = 4'($urandom);
            code = 8'($urandom);
            tick();
        end

        // 4: fault injection while code 11 is held.
        req = '0;
        wait_idle("t4_idle");
        tick();
        req = 4'b0001; code = 8'b0000_0011;
        tick();
        check("t4_gnt", 8'(gnt), 8'h01);
        req = '0; force_bad = 1;
        wait_idle("t4_fall");
        force_bad = 0;
        check("t4_nodone", 8'(done), 8'h00);
        check("t4_err",    8'(err),  8'h01);
        req = 4'b0010; code = 8'($urandom);
        repeat (12) tick();
        check("t4_sticky", 8'(err), 8'h01);

        // 5: reset in the first HOLD cycle.
        req = '0;
        wait_idle("t5_idle");
        tick();
        req = 4'b0001;
        wait_gnt("t5_first", 8'h01);
        reset = 1'b1; req = '0;
        tick();
        check("t5_zero", {x_out, y_out, busy, err, gnt}, 8'h00);
        check("t5_nodone", 8'(done), 8'h00);
        reset = 1'b0; req2 = 2'b01; req = 4'b0110;
        tick();
        check("t5_ptr", 8'(gnt), 8'h02);

        // More random traffic, then drain.
        repeat (100) begin
            req  = 4'($urandom);
            code = 8'($urandom);
            tick();
        end
        req = '0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
